centroid_steer_ctrl: RTL and testbench

Downstream consumer of the three `color_proc` instances: takes the per-camera colour centroid and proximity, fuses them into a single heading error across the 3-camera field of view, and drives two DC-motor PWM channels (differential steering) for the robot. Sits in the 50 MHz domain next to the display, replacing the LED centroid readout as the real consumer of `centroid_*`/`proximity_*`.

---
 rtl/steer_pkg.sv | 40 ++++
 rtl/pwm_gen.sv | 52 +++++
 rtl/centroid_steer_ctrl.sv | 236 +++++++++++++++++++++++
 tb/tb_centroid_steer_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/steer_pkg.sv
// Shared definitions for the centroid steering controller.
// Holds the FSM state encoding, per-camera zone offsets across the fused
// 24-zone field of view, the centre zone constant, and helpers for locating
// the target zone and saturating a signed duty into 0..255.
package steer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SEARCH = 2'd1,
        ST_TRACK  = 2'd2,
        ST_STOP   = 2'd3
    } steer_state_t;

    // Each camera covers 8 zones; left camera is leftmost in the fused view.
    localparam logic [4:0] ZONE_OFS_L  = 5'd0;
    localparam logic [4:0] ZONE_OFS_C  = 5'd8;
    localparam logic [4:0] ZONE_OFS_R  = 5'd16;
    localparam logic [4:0] ZONE_CENTRE = 5'd12;

    // Index of the highest set bit (bit 7 = leftmost zone of a camera).
    function automatic logic [2:0] hi_bit_idx(input logic [7:0] v);
        logic [2:0] idx;
        idx = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            if (v[i]) idx = 3'(i);
        end
        return idx;
    endfunction

    // Clamp a signed intermediate duty into the 8-bit PWM range.
    function automatic logic [7:0] sat_duty(input logic signed [10:0] v);
        if (v < 11'sd0)
            return '0;
        else if (v > 11'sd255)
            return '1;
        else
            return v[7:0];
    endfunction

endpackage

// File: rtl/pwm_gen.sv
// Single-channel PWM generator.
// A prescaler divides clk by c_pwm_div; each prescaled step advances an 8-bit
// counter. Output is high while counter < active duty, so duty 0 is constant
// low and 255 gives 255/256 high. The requested duty is copied into the
// active register only when the counter wraps, so a period is never cut
// short. force_off drives the output low on the next clock edge and clears
// the active duty, independent of the counter phase.
// Ports:
//   clk       system clock
//   rst       asynchronous active-low reset
//   force_off 1 = output low immediately, active duty cleared
//   duty      requested duty, sampled at counter wrap
//   pwm       registered PWM output
module pwm_gen #(
    parameter int unsigned c_pwm_div = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       force_off,
    input  logic [7:0] duty,
    output logic       pwm
);

    localparam int unsigned PW = (c_pwm_div > 1) ? $clog2(c_pwm_div) : 1;

    logic [PW-1:0] presc;
    logic [7:0]    cnt;
    logic [7:0]    duty_act;
    logic          step;

    assign step = (presc == PW'(c_pwm_div - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            presc    <= '0;
            cnt      <= '0;
            duty_act <= '0;
            pwm      <= 1'b0;
        end else begin
            presc <= step ? '0 : presc + 1'b1;
            if (step) cnt <= cnt + 8'd1;

            if (force_off)
                duty_act <= '0;
            else if (step && (cnt == 8'hFF))
                duty_act <= duty;

            pwm <= !force_off && (cnt < duty_act);
        end
    end

endmodule

// File: rtl/centroid_steer_ctrl.sv
// Centroid-driven differential steering controller.
// Samples the three per-camera zone-hot centroids and proximities on a slow
// update tick, fuses them into one heading error across the 24-zone field of
// view, runs the IDLE/SEARCH/TRACK/STOP FSM and drives two PWM motor channels
// with direction bits.
// Ports:
//   clk                      system clock
//   rst                      asynchronous active-low reset
//   enable                   level; 0 forces IDLE and motors off
//   centroid_l/_c/_r [7:0]   zone-hot centroid per camera, 0 = no object
//   proximity_l/_c/_r [2:0]  proximity per camera, larger = closer
//   motor_l_pwm/motor_r_pwm  PWM drive
//   motor_l_fwd/motor_r_fwd  direction, 1 = forward
//   state [1:0]              current FSM state
//   heading_err [5:0]        signed error of last accepted target
module centroid_steer_ctrl
    import steer_pkg::*;
#(
    parameter int unsigned c_upd_cycles  = 1_000_000,
    parameter int unsigned c_pwm_div     = 10,
    parameter int unsigned c_base_duty   = 160,
    parameter int unsigned c_gain        = 8,
    parameter int unsigned c_search_duty = 96,
    parameter int unsigned c_prox_stop   = 6,
    parameter int unsigned c_lost_upd    = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic [7:0]        centroid_l,
    input  logic [7:0]        centroid_c,
    input  logic [7:0]        centroid_r,
    input  logic [2:0]        proximity_l,
    input  logic [2:0]        proximity_c,
    input  logic [2:0]        proximity_r,
    output logic              motor_l_pwm,
    output logic              motor_r_pwm,
    output logic              motor_l_fwd,
    output logic              motor_r_fwd,
    output logic [1:0]        state,
    output logic signed [5:0] heading_err
);

    localparam int unsigned UW = (c_upd_cycles > 1) ? $clog2(c_upd_cycles) : 1;
    localparam int unsigned LW = $clog2(c_lost_upd + 1);

    localparam logic [3:0]        PROX_STOP   = 4'(c_prox_stop);
    localparam logic [3:0]        PROX_RESUME = 4'(c_prox_stop - 1);
    localparam logic [LW-1:0]     LOST_LIM    = LW'(c_lost_upd);
    localparam logic signed [10:0] BASE_S     = 11'(c_base_duty);
    localparam logic signed [10:0] GAIN_S     = 11'(c_gain);
    localparam logic [7:0]        SEARCH_D    = 8'(c_search_duty);

    // ---------------- update tick ----------------
    logic [UW-1:0] upd_cnt;
    logic          tick;

    assign tick = (upd_cnt == UW'(c_upd_cycles - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            upd_cnt <= '0;
        else
            upd_cnt <= tick ? '0 : upd_cnt + 1'b1;
    end

    // ---------------- target fusion ----------------
    logic [7:0]        sel_vec;
    logic [4:0]        sel_ofs;
    logic [2:0]        sel_prox;
    logic              has_target;
    logic [4:0]        zone;
    logic signed [5:0] target_err;
    logic              near;
    logic              far;

    always_comb begin
        sel_vec    = '0;
        sel_ofs    = '0;
        sel_prox   = '0;
        has_target = 1'b1;
        if (centroid_c != '0) begin
            sel_vec  = centroid_c;
            sel_ofs  = ZONE_OFS_C;
            sel_prox = proximity_c;
        end else if (centroid_l != '0) begin
            sel_vec  = centroid_l;
            sel_ofs  = ZONE_OFS_L;
            sel_prox = proximity_l;
        end else if (centroid_r != '0) begin
            sel_vec  = centroid_r;
            sel_ofs  = ZONE_OFS_R;
            sel_prox = proximity_r;
        end else begin
            has_target = 1'b0;
        end
    end

    assign zone       = sel_ofs + (5'd7 - {2'b00, hi_bit_idx(sel_vec)});
    assign target_err = $signed({1'b0, zone} - {1'b0, ZONE_CENTRE});
    assign near       = ({1'b0, sel_prox} >= PROX_STOP);
    // One level of hysteresis: leave STOP only once clearly further away.
    assign far        = ({1'b0, sel_prox} < PROX_RESUME);

    // ---------------- FSM ----------------
    steer_state_t      state_q, state_nx;
    logic [LW-1:0]     lost_q, lost_nx, lost_inc;
    logic signed [5:0] err_nx;

    assign lost_inc = lost_q + 1'b1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            lost_q      <= '0;
            heading_err <= '0;
        end else begin
            state_q     <= state_nx;
            lost_q      <= lost_nx;
            heading_err <= err_nx;
        end
    end

    always_comb begin
        state_nx = state_q;
        lost_nx  = lost_q;
        err_nx   = heading_err;
        if (!enable) begin
            state_nx = ST_IDLE;
            lost_nx  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    state_nx = ST_SEARCH;
                    lost_nx  = '0;
                end
                ST_SEARCH: begin
                    lost_nx = '0;
                    if (tick && has_target) begin
                        err_nx   = target_err;
                        state_nx = near ? ST_STOP : ST_TRACK;
                    end
                end
                ST_TRACK, ST_STOP: begin
                    // A target present on the tick always wins over the lost limit.
                    if (tick) begin
                        if (has_target) begin
                            err_nx  = target_err;
                            lost_nx = '0;
                            if (state_q == ST_TRACK)
                                state_nx = near ? ST_STOP : ST_TRACK;
                            else
                                state_nx = far ? ST_TRACK : ST_STOP;
                        end else if (lost_inc >= LOST_LIM) begin
                            state_nx = ST_SEARCH;
                            lost_nx  = '0;
                        end else begin
                            lost_nx = lost_inc;
                        end
                    end
                end
                default: state_nx = ST_IDLE;
            endcase
        end
    end

    assign state = state_q;

    // ---------------- duty arithmetic ----------------
    logic signed [10:0] err_x;
    logic signed [10:0] track_l;
    logic signed [10:0] track_r;
    logic [7:0]         duty_l_nx, duty_r_nx, duty_l, duty_r;
    logic               fwd_l_nx, fwd_r_nx;

    assign err_x   = {{5{heading_err[5]}}, heading_err};
    assign track_l = BASE_S + GAIN_S * err_x;
    assign track_r = BASE_S - GAIN_S * err_x;

    always_comb begin
        duty_l_nx = '0;
        duty_r_nx = '0;
        fwd_l_nx  = 1'b1;
        fwd_r_nx  = 1'b1;
        unique case (state_q)
            ST_TRACK: begin
                duty_l_nx = sat_duty(track_l);
                duty_r_nx = sat_duty(track_r);
            end
            ST_SEARCH: begin
                // Spin toward the side the target was last seen on.
                duty_l_nx = SEARCH_D;
                duty_r_nx = SEARCH_D;
                fwd_l_nx  = !heading_err[5];
                fwd_r_nx  = heading_err[5];
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            duty_l      <= '0;
            duty_r      <= '0;
            motor_l_fwd <= 1'b1;
            motor_r_fwd <= 1'b1;
        end else begin
            duty_l      <= duty_l_nx;
            duty_r      <= duty_r_nx;
            motor_l_fwd <= fwd_l_nx;
            motor_r_fwd <= fwd_r_nx;
        end
    end

    // ---------------- PWM channels ----------------
    logic force_off;

    assign force_off = (state_q == ST_IDLE) || !enable;

    pwm_gen #(.c_pwm_div(c_pwm_div)) u_pwm_l (
        .clk       (clk),
        .rst       (rst),
        .force_off (force_off),
        .duty      (duty_l),
        .pwm       (motor_l_pwm)
    );

    pwm_gen #(.c_pwm_div(c_pwm_div)) u_pwm_r (
        .clk       (clk),
        .rst       (rst),
        .force_off (force_off),
        .duty      (duty_r),
        .pwm       (motor_r_pwm)
    );

endmodule

// File: tb/tb_centroid_steer_ctrl.sv
module tb_centroid_steer_ctrl;

    localparam int UPD   = 100;
    localparam int DIV   = 1;
    localparam int BASE  = 160;
    localparam int GAIN  = 8;
    localparam int SRCH  = 96;
    localparam int PSTOP = 6;
    localparam int LOST  = 25;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              enable = 1'b0;
    logic [7:0]        cl = '0, cc = '0, cr = '0;
    logic [2:0]        pl = '0, pc = '0, pr = '0;
    logic              pwm_l, pwm_r, fwd_l, fwd_r;
    logic [1:0]        state;
    logic signed [5:0] heading_err;

    int checks = 0;
    int errors = 0;

    // behavioural model
    int m_state = 0;  // 0 IDLE, 1 SEARCH, 2 TRACK, 3 STOP
    int m_err   = 0;
    int m_lost  = 0;
    int edge_n  = 0;
    bit m_tick  = 0;

    always #5 clk = ~clk;

    centroid_steer_ctrl #(
        .c_upd_cycles (UPD),
        .c_pwm_div    (DIV),
        .c_base_duty  (BASE),
        .c_gain       (GAIN),
        .c_search_duty(SRCH),
        .c_prox_stop  (PSTOP),
        .c_lost_upd   (LOST)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .centroid_l (cl),
        .centroid_c (cc),
        .centroid_r (cr),
        .proximity_l(pl),
        .proximity_c(pc),
        .proximity_r(pr),
        .motor_l_pwm(pwm_l),
        .motor_r_pwm(pwm_r),
        .motor_l_fwd(fwd_l),
        .motor_r_fwd(fwd_r),
        .state      (state),
        .heading_err(heading_err)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Fused 24-zone view: cameras in priority order, first set bit from the left.
    task automatic find_target(output bit pres, output int z, output int p);
        logic [7:0] vec [3];
        int         ofs [3];
        int         prox[3];
        vec[0] = cc; ofs[0] = 8;  prox[0] = int'(pc);
        vec[1] = cl; ofs[1] = 0;  prox[1] = int'(pl);
        vec[2] = cr; ofs[2] = 16; prox[2] = int'(pr);
        pres = 0; z = 0; p = 0;
        for (int c = 0; c < 3 && !pres; c++) begin
            for (int k = 0; k < 8 && !pres; k++) begin
                if (vec[c][7-k]) begin
                    pres = 1;
                    z    = ofs[c] + k;
                    p    = prox[c];
                end
            end
        end
    endtask

    task automatic model_edge();
        bit pres;
        int z, p;
        m_tick = 0;
        if (!rst) begin
            m_state = 0; m_err = 0; m_lost = 0; edge_n = 0;
            return;
        end
        edge_n++;
        m_tick = (edge_n % UPD) == 0;
        if (!enable) begin
            m_state = 0; m_lost = 0;
            return;
        end
        if (m_state == 0) begin
            m_state = 1; m_lost = 0;
            return;
        end
        if (m_state == 1) m_lost = 0;
        if (!m_tick) return;
        find_target(pres, z, p);
        if (pres) begin
            m_err  = z - 12;
            m_lost = 0;
            if (m_state == 3) m_state = (p < PSTOP - 1) ? 2 : 3;
            else              m_state = (p >= PSTOP) ? 3 : 2;
        end else if (m_state >= 2) begin
            m_lost++;
            if (m_lost >= LOST) begin
                m_state = 1; m_lost = 0;
            end
        end
    endtask

    function automatic int exp_duty(input bit left);
        int v;
        case (m_state)
            2: begin
                v = left ? BASE + GAIN * m_err : BASE - GAIN * m_err;
                if (v < 0) v = 0;
                if (v > 255) v = 255;
                return v;
            end
            1:       return SRCH;
            default: return 0;
        endcase
    endfunction

    function automatic int exp_fwd(input bit left);
        if (m_state == 1) return left ? int'(m_err >= 0) : int'(m_err < 0);
        return 1;
    endfunction

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic to_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (!m_tick && n < UPD + 1);
    endtask

    task automatic chk_tick(input string tag);
        to_tick();
        chk({tag, "_state"}, state, m_state);
        chk({tag, "_err"}, heading_err, m_err);
    endtask

    task automatic chk_fwd(input string tag);
        chk({tag, "_fwd_l"}, fwd_l, exp_fwd(1));
        chk({tag, "_fwd_r"}, fwd_r, exp_fwd(0));
    endtask

    task automatic measure(input string tag);
        int hl, hr;
        hl = 0; hr = 0;
        repeat (260) step();
        repeat (256) begin
            step();
            hl += int'(pwm_l);
            hr += int'(pwm_r);
        end
        chk({tag, "_duty_l"}, hl, exp_duty(1));
        chk({tag, "_duty_r"}, hr, exp_duty(0));
        chk_fwd(tag);
    endtask

    task automatic wait_pwm_l_high(input string tag);
        int n;
        n = 0;
        while (pwm_l !== 1'b1 && n < 600) begin
            step();
            n++;
        end
        chk({tag, "_pwm_l_seen_high"}, pwm_l, 1);
    endtask

    initial begin
        // reset state
        repeat (3) step();
        chk("rst_state", state, 0);
        chk("rst_err", heading_err, 0);
        chk("rst_pwm_l", pwm_l, 0);
        chk("rst_pwm_r", pwm_r, 0);
        chk("rst_fwd_l", fwd_l, 1);
        chk("rst_fwd_r", fwd_r, 1);

        // release, enable: SEARCH after one cycle, spin right by default
        rst = 1'b1;
        enable = 1'b1;
        step();
        chk("en_search", state, 1);
        chk_tick("search_tick");
        step();
        chk_fwd("search_dir");
        measure("search");

        // centre camera, zone 11 -> e = -1
        cc = 8'h10; pc = 3'd2;
        chk_tick("ctr");
        chk("ctr_err_lit", heading_err, -1);
        measure("ctr");

        // right camera rightmost -> e = +11
        cc = '0; cr = 8'h01; pr = 3'd1;
        chk_tick("right");
        measure("right");

        // left camera leftmost -> e = -12, R saturates
        cr = '0; cl = 8'h80; pl = 3'd0;
        chk_tick("left");
        measure("left");

        // proximity hysteresis
        cl = '0; cc = 8'h10; pc = 3'd6;
        chk_tick("prox6");
        measure("prox6");
        pc = 3'd5;
        chk_tick("prox5");
        pc = 3'd4;
        chk_tick("prox4");
        measure("prox4");

        // lost target: 24 ticks keep TRACK, 25th goes SEARCH toward last side
        cc = '0;
        for (int i = 0; i < LOST - 1; i++) chk_tick("lost");
        cc = '0;
        chk_tick("lost25");
        step();
        chk_fwd("lost_dir");
        measure("lost_search");

        // target reappears on the very tick the lost limit is hit
        cc = 8'h10; pc = 3'd2;
        chk_tick("reacq");
        cc = '0;
        for (int i = 0; i < LOST - 1; i++) to_tick();
        chk("pre_limit_state", state, m_state);
        cl = 8'h01; pl = 3'd1;
        chk_tick("limit_target_wins");

        // randomized phase
        for (int i = 0; i < 80; i++) begin
            cl = ($urandom_range(1) != 0) ? 8'($urandom) : '0;
            cc = ($urandom_range(2) == 0) ? 8'($urandom) : '0;
            cr = ($urandom_range(1) != 0) ? 8'($urandom) : '0;
            pl = 3'($urandom); pc = 3'($urandom); pr = 3'($urandom);
            if ($urandom_range(9) == 0) begin
                enable = 1'b0;
                step();
                chk("rnd_dis_state", state, 0);
                chk("rnd_dis_pwm_l", pwm_l, 0);
                chk("rnd_dis_pwm_r", pwm_r, 0);
                enable = 1'b1;
                step();
                chk("rnd_reen_state", state, m_state);
            end else begin
                chk_tick("rnd");
                step();
                chk_fwd("rnd");
            end
        end

        // disable mid-period with duty 200: e = +5 via right camera bit 6
        cl = '0; cc = '0; cr = 8'h40; pr = 3'd2;
        pl = '0; pc = '0;
        to_tick();
        to_tick();
        chk("d200_state", state, 2);
        chk("d200_err", heading_err, 5);
        measure("d200");
        wait_pwm_l_high("d200");
        enable = 1'b0;
        step();
        chk("dis_state", state, 0);
        chk("dis_pwm_l", pwm_l, 0);
        chk("dis_pwm_r", pwm_r, 0);

        // asynchronous reset mid-period
        enable = 1'b1;
        to_tick();
        to_tick();
        repeat (300) step();
        wait_pwm_l_high("arst");
        rst = 1'b0;
        #2;
        chk("arst_pwm_l", pwm_l, 0);
        chk("arst_pwm_r", pwm_r, 0);
        chk("arst_state", state, 0);
        chk("arst_err", heading_err, 0);
        chk("arst_fwd_l", fwd_l, 1);
        chk("arst_fwd_r", fwd_r, 1);
        step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
